// File: rtl/mxint_cast_arbiter.sv
// Round-robin arbiter sharing one mxint_cast instance between NUM_REQ block streams.
// A tag FIFO records the issuing requester of each block so results return in issue order.
module mxint_cast_arbiter #(
    parameter int unsigned NUM_REQ       = 2,
    parameter int unsigned BLOCK_SIZE    = 4,
    parameter int unsigned IN_MAN_WIDTH  = 8,
    parameter int unsigned IN_EXP_WIDTH  = 8,
    parameter int unsigned OUT_MAN_WIDTH = 8,
    parameter int unsigned OUT_EXP_WIDTH = 8,
    parameter int unsigned TAG_DEPTH     = 4
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic [NUM_REQ*BLOCK_SIZE*IN_MAN_WIDTH-1:0]  req_mdata_in,
    input  logic [NUM_REQ*IN_EXP_WIDTH-1:0]             req_edata_in,
    input  logic [NUM_REQ-1:0]                          req_valid,
    output logic [NUM_REQ-1:0]                          req_ready,
    output logic [BLOCK_SIZE*IN_MAN_WIDTH-1:0]          cast_mdata,
    output logic [IN_EXP_WIDTH-1:0]                     cast_edata,
    output logic                                        cast_in_valid,
    input  logic                                        cast_in_ready,
    input  logic [BLOCK_SIZE*OUT_MAN_WIDTH-1:0]         cast_mresult,
    input  logic [OUT_EXP_WIDTH-1:0]                    cast_eresult,
    input  logic                                        cast_out_valid,
    output logic                                        cast_out_ready,
    output logic [BLOCK_SIZE*OUT_MAN_WIDTH-1:0]         rsp_mdata_out,
    output logic [OUT_EXP_WIDTH-1:0]                    rsp_edata_out,
    output logic [NUM_REQ-1:0]                          rsp_valid,
    input  logic [NUM_REQ-1:0]                          rsp_ready,
    output logic [$clog2(TAG_DEPTH+1)-1:0]              in_flight,
    output logic                                        tag_error
);

    localparam int unsigned ID_W     = $clog2(NUM_REQ);
    localparam int unsigned PTR_W    = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int unsigned CNT_W    = $clog2(TAG_DEPTH + 1);
    localparam int unsigned BLK_IN_W = BLOCK_SIZE * IN_MAN_WIDTH;

    logic [ID_W-1:0]  rr_ptr;
    logic [ID_W-1:0]  locked_id;
    logic             lock;
    logic [ID_W-1:0]  rr_grant;
    logic [ID_W-1:0]  grant;
    logic [ID_W-1:0]  head;
    logic [ID_W-1:0]  tag_mem [TAG_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             fifo_empty;
    logic             issue_en;
    logic             push;
    logic             pop;

    always_comb begin : rr_search
        int unsigned idx;
        logic        found;
        idx      = 0;
        found    = 1'b0;
        rr_grant = rr_ptr;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            idx = (32'(rr_ptr) + i) % NUM_REQ;
            if (!found && req_valid[ID_W'(idx)]) begin
                rr_grant = ID_W'(idx);
                found    = 1'b1;
            end
        end
    end

    // A stalled offer keeps its requester so grant and data stay stable until accepted.
    assign grant = lock ? locked_id : rr_grant;

    always_comb begin
        cast_mdata = '0;
        cast_edata = '0;
        for (int unsigned r = 0; r < NUM_REQ; r++) begin
            if (ID_W'(r) == grant) begin
                cast_mdata = req_mdata_in[r*BLK_IN_W +: BLK_IN_W];
                cast_edata = req_edata_in[r*IN_EXP_WIDTH +: IN_EXP_WIDTH];
            end
        end
    end

    assign fifo_empty = (in_flight == '0);
    assign head       = tag_mem[rd_ptr];

    always_comb begin
        rsp_valid      = '0;
        cast_out_ready = !rst && !fifo_empty && rsp_ready[head];
        if (!rst && !fifo_empty && cast_out_valid)
            rsp_valid[head] = 1'b1;
    end

    assign pop      = cast_out_valid && cast_out_ready;
    assign issue_en = ((|req_valid) || lock) && ((in_flight < CNT_W'(TAG_DEPTH)) || pop);

    always_comb begin
        req_ready     = '0;
        cast_in_valid = !rst && issue_en && req_valid[grant];
        if (!rst && issue_en && cast_in_ready)
            req_ready[grant] = 1'b1;
    end

    assign push = cast_in_valid && cast_in_ready;

    assign rsp_mdata_out = cast_mresult;
    assign rsp_edata_out = cast_eresult;

    // Tag storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push)
            tag_mem[wr_ptr] <= grant;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr    <= '0;
            locked_id <= '0;
            lock      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            in_flight <= '0;
            tag_error <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= (wr_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
                rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                lock   <= 1'b0;
            end else if (cast_in_valid) begin
                lock      <= 1'b1;
                locked_id <= grant;
            end

            if (pop)
                rd_ptr <= (rd_ptr == PTR_W'(TAG_DEPTH - 1)) ? '0 : rd_ptr + 1'b1;

            case ({push, pop})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase

            if (cast_out_valid && fifo_empty)
                tag_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_mxint_cast_arbiter.sv
// Directed bench for mxint_cast_arbiter at default parameters (2 requesters, 4 tags).
// Each task drives one scenario and checks hand-computed expectations inline.
module tb_mxint_cast_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] req_mdata_in;
    logic [15:0] req_edata_in;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] cast_mdata;
    logic [7:0]  cast_edata;
    logic        cast_in_valid;
    logic        cast_in_ready;
    logic [31:0] cast_mresult;
    logic [7:0]  cast_eresult;
    logic        cast_out_valid;
    logic        cast_out_ready;
    logic [31:0] rsp_mdata_out;
    logic [7:0]  rsp_edata_out;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready;
    logic [2:0]  in_flight;
    logic        tag_error;

    int n_cmp = 0;
    int n_err = 0;

    mxint_cast_arbiter #(
        .NUM_REQ(2), .BLOCK_SIZE(4), .IN_MAN_WIDTH(8), .IN_EXP_WIDTH(8),
        .OUT_MAN_WIDTH(8), .OUT_EXP_WIDTH(8), .TAG_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .req_mdata_in(req_mdata_in), .req_edata_in(req_edata_in),
        .req_valid(req_valid), .req_ready(req_ready),
        .cast_mdata(cast_mdata), .cast_edata(cast_edata),
        .cast_in_valid(cast_in_valid), .cast_in_ready(cast_in_ready),
        .cast_mresult(cast_mresult), .cast_eresult(cast_eresult),
        .cast_out_valid(cast_out_valid), .cast_out_ready(cast_out_ready),
        .rsp_mdata_out(rsp_mdata_out), .rsp_edata_out(rsp_edata_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .in_flight(in_flight), .tag_error(tag_error)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    task automatic clear_inputs();
        req_mdata_in   = '0;
        req_edata_in   = '0;
        req_valid      = '0;
        cast_in_ready  = 1'b0;
        cast_mresult   = '0;
        cast_eresult   = '0;
        cast_out_valid = 1'b0;
        rsp_ready      = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst = 1'b1;
        req_valid = 2'b11; cast_in_ready = 1'b1; cast_out_valid = 1'b1; rsp_ready = 2'b11;
        @(posedge clk); #1;
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_req_ready: got %b expected 00", req_ready); end
        n_cmp++; if (cast_in_valid !== 1'b0) begin n_err++; $display("FAIL reset_cast_in_valid: got %b expected 0", cast_in_valid); end
        n_cmp++; if (cast_out_ready !== 1'b0) begin n_err++; $display("FAIL reset_cast_out_ready: got %b expected 0", cast_out_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
        n_cmp++; if (in_flight !== 3'd0) begin n_err++; $display("FAIL reset_in_flight: got %0d expected 0", in_flight); end
        n_cmp++; if (tag_error !== 1'b0) begin n_err++; $display("FAIL reset_tag_error: got %b expected 0", tag_error); end
        clear_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    // Requester 0 sends 3 blocks through a latency-2 stub returning exponent+1.
    task automatic test_single();
        logic [7:0] q_e[$];
        logic [7:0] exp_e;
        int q_t[$];
        int issued = 0, popped = 0, peak = 0, bad1 = 0, pulses0 = 0;
        do_reset();
        for (int c = 0; c < 12; c++) begin
            req_valid     = (issued < 3) ? 2'b01 : 2'b00;
            req_edata_in  = {8'h00, 8'h10 + 8'(issued)};
            req_mdata_in  = {32'h0, {4{8'h10 + 8'(issued)}}};
            cast_in_ready = 1'b1;
            rsp_ready     = 2'b11;
            if (q_t.size() > 0 && q_t[0] <= c) begin
                cast_out_valid = 1'b1;
                cast_eresult   = 8'(q_e[0] + 8'd1);
                cast_mresult   = {4{q_e[0]}};
            end else begin
                cast_out_valid = 1'b0;
            end
            #1;
            if (rsp_valid[1]) bad1++;
            if (rsp_valid[0]) pulses0++;
            if (cast_in_valid && cast_in_ready) begin
                q_e.push_back(cast_edata);
                q_t.push_back(c + 2);
                issued++;
            end
            if (cast_out_valid && cast_out_ready) begin
                exp_e = 8'h11 + 8'(popped);
                n_cmp++; if (rsp_edata_out !== exp_e) begin n_err++; $display("FAIL single_rsp_edata: got %h expected %h", rsp_edata_out, exp_e); end
                exp_e = 8'h10 + 8'(popped);
                n_cmp++; if (rsp_mdata_out !== {4{exp_e}}) begin n_err++; $display("FAIL single_rsp_mdata: got %h expected %h", rsp_mdata_out, {4{exp_e}}); end
                void'(q_e.pop_front());
                void'(q_t.pop_front());
                popped++;
            end
            @(posedge clk); #1;
            if (int'(in_flight) > peak) peak = int'(in_flight);
        end
        n_cmp++; if (issued !== 3) begin n_err++; $display("FAIL single_issues: got %0d expected 3", issued); end
        n_cmp++; if (pulses0 !== 3) begin n_err++; $display("FAIL single_rsp0_pulses: got %0d expected 3", pulses0); end
        n_cmp++; if (bad1 !== 0) begin n_err++; $display("FAIL single_rsp1_pulses: got %0d expected 0", bad1); end
        n_cmp++; if (peak !== 2) begin n_err++; $display("FAIL single_in_flight_peak: got %0d expected 2", peak); end
        n_cmp++; if (in_flight !== 3'd0) begin n_err++; $display("FAIL single_in_flight_end: got %0d expected 0", in_flight); end
    endtask

    task automatic test_fairness();
        logic [1:0] exp_rdy;
        logic [7:0] exp_e;
        do_reset();
        req_edata_in = {8'hB1, 8'hA0};
        for (int i = 0; i < 6; i++) begin
            req_valid      = 2'b11;
            cast_in_ready  = 1'b1;
            cast_out_valid = (in_flight != 3'd0);
            rsp_ready      = 2'b11;
            #1;
            exp_rdy = (i % 2 == 1) ? 2'b10 : 2'b01;
            exp_e   = (i % 2 == 1) ? 8'hB1 : 8'hA0;
            n_cmp++; if (req_ready !== exp_rdy) begin n_err++; $display("FAIL fair_req_ready[%0d]: got %b expected %b", i, req_ready, exp_rdy); end
            n_cmp++; if (cast_edata !== exp_e) begin n_err++; $display("FAIL fair_cast_edata[%0d]: got %h expected %h", i, cast_edata, exp_e); end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stall_lock();
        do_reset();
        req_edata_in = {8'hB1, 8'hA0};
        req_valid = 2'b01; cast_in_ready = 1'b1;
        @(posedge clk); #1;
        for (int c = 0; c < 3; c++) begin
            req_valid     = (c == 0) ? 2'b01 : 2'b11;
            cast_in_ready = 1'b0;
            #1;
            n_cmp++; if (cast_in_valid !== 1'b1) begin n_err++; $display("FAIL stall_valid[%0d]: got %b expected 1", c, cast_in_valid); end
            n_cmp++; if (cast_edata !== 8'hA0) begin n_err++; $display("FAIL stall_edata[%0d]: got %h expected a0", c, cast_edata); end
            n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL stall_req_ready[%0d]: got %b expected 00", c, req_ready); end
            @(posedge clk); #1;
        end
        req_valid = 2'b11; cast_in_ready = 1'b1;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL stall_accept_ready: got %b expected 01", req_ready); end
        n_cmp++; if (cast_edata !== 8'hA0) begin n_err++; $display("FAIL stall_accept_edata: got %h expected a0", cast_edata); end
        @(posedge clk); #1;
        req_valid = 2'b10;
        #1;
        n_cmp++; if (req_ready !== 2'b10) begin n_err++; $display("FAIL stall_next_ready: got %b expected 10", req_ready); end
        n_cmp++; if (cast_edata !== 8'hB1) begin n_err++; $display("FAIL stall_next_edata: got %h expected b1", cast_edata); end
        @(posedge clk); #1;
        req_valid = 2'b00;
        n_cmp++; if (in_flight !== 3'd3) begin n_err++; $display("FAIL stall_in_flight: got %0d expected 3", in_flight); end
    endtask

    task automatic test_tag_full();
        int accepts = 0;
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req_valid = 2'b01; cast_in_ready = 1'b1;
            #1;
            if (cast_in_valid && cast_in_ready) accepts++;
            @(posedge clk); #1;
        end
        n_cmp++; if (accepts !== 4) begin n_err++; $display("FAIL full_accepts: got %0d expected 4", accepts); end
        n_cmp++; if (in_flight !== 3'd4) begin n_err++; $display("FAIL full_in_flight: got %0d expected 4", in_flight); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL full_req_ready: got %b expected 00", req_ready); end
        n_cmp++; if (cast_in_valid !== 1'b0) begin n_err++; $display("FAIL full_cast_in_valid: got %b expected 0", cast_in_valid); end
        cast_out_valid = 1'b1; rsp_ready = 2'b01;
        #1;
        n_cmp++; if (req_ready !== 2'b01) begin n_err++; $display("FAIL full_swap_req_ready: got %b expected 01", req_ready); end
        n_cmp++; if (cast_out_ready !== 1'b1) begin n_err++; $display("FAIL full_swap_out_ready: got %b expected 1", cast_out_ready); end
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL full_swap_rsp_valid: got %b expected 01", rsp_valid); end
        @(posedge clk); #1;
        cast_out_valid = 1'b0; req_valid = 2'b00;
        n_cmp++; if (in_flight !== 3'd4) begin n_err++; $display("FAIL full_swap_in_flight: got %0d expected 4", in_flight); end
    endtask

    task automatic test_return_backpressure();
        do_reset();
        cast_in_ready = 1'b1;
        req_valid = 2'b10;
        @(posedge clk); #1;
        req_valid = 2'b01;
        @(posedge clk); #1;
        req_valid = 2'b00;
        n_cmp++; if (in_flight !== 3'd2) begin n_err++; $display("FAIL bp_in_flight_issued: got %0d expected 2", in_flight); end
        for (int c = 0; c < 5; c++) begin
            cast_out_valid = 1'b1; cast_eresult = 8'h51; rsp_ready = 2'b01;
            #1;
            n_cmp++; if (cast_out_ready !== 1'b0) begin n_err++; $display("FAIL bp_out_ready[%0d]: got %b expected 0", c, cast_out_ready); end
            n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL bp_rsp_valid[%0d]: got %b expected 10", c, rsp_valid); end
            @(posedge clk); #1;
        end
        n_cmp++; if (in_flight !== 3'd2) begin n_err++; $display("FAIL bp_in_flight_held: got %0d expected 2", in_flight); end
        rsp_ready = 2'b11;
        #1;
        n_cmp++; if (rsp_valid !== 2'b10) begin n_err++; $display("FAIL bp_rel_rsp_valid: got %b expected 10", rsp_valid); end
        n_cmp++; if (cast_out_ready !== 1'b1) begin n_err++; $display("FAIL bp_rel_out_ready: got %b expected 1", cast_out_ready); end
        n_cmp++; if (rsp_edata_out !== 8'h51) begin n_err++; $display("FAIL bp_rel_edata: got %h expected 51", rsp_edata_out); end
        @(posedge clk); #1;
        cast_eresult = 8'h50;
        #1;
        n_cmp++; if (rsp_valid !== 2'b01) begin n_err++; $display("FAIL bp_second_rsp_valid: got %b expected 01", rsp_valid); end
        n_cmp++; if (cast_out_ready !== 1'b1) begin n_err++; $display("FAIL bp_second_out_ready: got %b expected 1", cast_out_ready); end
        @(posedge clk); #1;
        cast_out_valid = 1'b0;
        n_cmp++; if (in_flight !== 3'd0) begin n_err++; $display("FAIL bp_in_flight_end: got %0d expected 0", in_flight); end
    endtask

    task automatic test_error_reset();
        do_reset();
        cast_out_valid = 1'b1; rsp_ready = 2'b11;
        #1;
        n_cmp++; if (cast_out_ready !== 1'b0) begin n_err++; $display("FAIL err_out_ready: got %b expected 0", cast_out_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL err_rsp_valid: got %b expected 00", rsp_valid); end
        n_cmp++; if (tag_error !== 1'b0) begin n_err++; $display("FAIL err_before_edge: got %b expected 0", tag_error); end
        @(posedge clk); #1;
        n_cmp++; if (tag_error !== 1'b1) begin n_err++; $display("FAIL err_set: got %b expected 1", tag_error); end
        cast_out_valid = 1'b0;
        req_valid = 2'b11; cast_in_ready = 1'b1; rsp_ready = 2'b00;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_cmp++; if (tag_error !== 1'b1) begin n_err++; $display("FAIL err_sticky: got %b expected 1", tag_error); end
        n_cmp++; if (in_flight !== 3'd2) begin n_err++; $display("FAIL err_in_flight_pre: got %0d expected 2", in_flight); end
        cast_out_valid = 1'b1; rsp_ready = 2'b11;
        #2;
        rst = 1'b1;
        #1;
        n_cmp++; if (in_flight !== 3'd0) begin n_err++; $display("FAIL arst_in_flight: got %0d expected 0", in_flight); end
        n_cmp++; if (tag_error !== 1'b0) begin n_err++; $display("FAIL arst_tag_error: got %b expected 0", tag_error); end
        n_cmp++; if (req_ready !== 2'b00) begin n_err++; $display("FAIL arst_req_ready: got %b expected 00", req_ready); end
        n_cmp++; if (cast_in_valid !== 1'b0) begin n_err++; $display("FAIL arst_cast_in_valid: got %b expected 0", cast_in_valid); end
        n_cmp++; if (cast_out_ready !== 1'b0) begin n_err++; $display("FAIL arst_cast_out_ready: got %b expected 0", cast_out_ready); end
        n_cmp++; if (rsp_valid !== 2'b00) begin n_err++; $display("FAIL arst_rsp_valid: got %b expected 00", rsp_valid); end
        @(posedge clk); #1;
        clear_inputs();
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_single();
        test_fairness();
        test_stall_lock();
        test_tag_full();
        test_return_backpressure();
        test_error_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mxint_cast_arbiter.md
Name: mxint_cast_arbiter

Overview:
- Shares one mxint_cast datapath instance between NUM_REQ independent MxInt block streams.
- Arbitrates requester blocks round-robin into the shared cast.
- Records the issuing requester ID in an internal tag FIFO.
- Routes each cast result back to the requester that issued it, in issue order.
- Sits between several layer outputs and a single cast instance, so cast hardware is not replicated per layer.

Parameters:
NUM_REQ, 2, number of requester streams (>=2)
BLOCK_SIZE, 4, mantissas per MxInt block
IN_MAN_WIDTH, 8, requester mantissa width (cast input side)
IN_EXP_WIDTH, 8, requester exponent width
OUT_MAN_WIDTH, 8, cast result mantissa width
OUT_EXP_WIDTH, 8, cast result exponent width
TAG_DEPTH, 4, maximum blocks in flight inside the cast (tag FIFO entries, >=1)

Ports:
clk  in  1  clock
rst  in  1  reset
req_mdata_in  in  NUM_REQ*BLOCK_SIZE*IN_MAN_WIDTH  requester mantissas, requester r at slice r
req_edata_in  in  NUM_REQ*IN_EXP_WIDTH  requester exponents
req_valid  in  NUM_REQ  per-requester valid
req_ready  out  NUM_REQ  per-requester ready
cast_mdata  out  BLOCK_SIZE*IN_MAN_WIDTH  mantissas to cast
cast_edata  out  IN_EXP_WIDTH  exponent to cast
cast_in_valid  out  1  to cast data_in_valid
cast_in_ready  in  1  from cast data_in_ready
cast_mresult  in  BLOCK_SIZE*OUT_MAN_WIDTH  cast result mantissas
cast_eresult  in  OUT_EXP_WIDTH  cast result exponent
cast_out_valid  in  1  from cast data_out_valid
cast_out_ready  out  1  to cast data_out_ready
rsp_mdata_out  out  BLOCK_SIZE*OUT_MAN_WIDTH  result mantissas, broadcast to all requesters
rsp_edata_out  out  OUT_EXP_WIDTH  result exponent, broadcast
rsp_valid  out  NUM_REQ  per-requester result valid
rsp_ready  in  NUM_REQ  per-requester result ready
in_flight  out  $clog2(TAG_DEPTH+1)  blocks issued and not yet returned
tag_error  out  1  sticky: cast_out_valid seen while tag FIFO empty

Behaviour:
- Interface: single clock clk. rst is asynchronous, active-high.
- Reset values: rr_ptr=0, lock=0, in_flight=0, tag FIFO empty, tag_error=0.
- During reset, all outputs are low or zero: req_ready, cast_in_valid, cast_out_ready, rsp_valid.
- Grant selection:
  - If lock=0, grant = first r with req_valid[r]=1, searching rr_ptr, rr_ptr+1, ... modulo NUM_REQ. This is combinational.
  - If lock=1, grant = locked_id.
- Issue enable: issue_en = (any req_valid, or lock=1) AND (in_flight < TAG_DEPTH, or a response pop occurs this cycle).
- cast_in_valid = issue_en AND req_valid[grant].
- cast_mdata and cast_edata = slice[grant].
- req_ready[grant] = cast_in_ready AND issue_en. All other req_ready are 0.
- Zero added latency on the issue path. The path is combinational from req to cast.
- Stability rule:
  - When cast_in_valid=1 and cast_in_ready=0, set lock=1 and locked_id=grant.
  - lock clears on the next accepted issue.
  - Grant and data must not change while valid is pending. Requesters keep valid and data stable, per the codebase handshake.
- On accepted issue (cast_in_valid AND cast_in_ready):
  - Push grant into the tag FIFO.
  - rr_ptr <= (grant+1) mod NUM_REQ.
  - lock <= 0.
- Return path:
  - head = tag FIFO head.
  - rsp_valid[head] = cast_out_valid AND fifo non-empty. Other rsp_valid are 0.
  - cast_out_ready = rsp_ready[head] AND fifo non-empty.
  - rsp data is cast_mresult/cast_eresult passed through combinationally.
  - On handshake, pop the tag FIFO.
- Simultaneous push and pop: in_flight is unchanged. A push is allowed when full only if a pop occurs in the same cycle.
- Tag FIFO: circular buffer with pointers of width $clog2(TAG_DEPTH). Wrap at TAG_DEPTH-1 back to 0, including when TAG_DEPTH is not a power of 2.
- Error case: cast_out_valid=1 with the FIFO empty sets tag_error=1. Only rst clears it. cast_out_ready stays 0 in this case.
- Backpressure from one requester's rsp_ready blocks all returns (in-order). Issue continues until in_flight reaches TAG_DEPTH.
- Reset mid-operation: all state clears immediately. In-flight blocks inside the cast are the system's responsibility; the cast shares the same rst.

Test Plan:
- Single requester: NUM_REQ=2, req_valid=01, 3 blocks, cast stub of latency 2 with ready=1 -> 3 cast issues, rsp_valid[0] pulses 3 times, rsp_valid[1] never asserts, in_flight peaks at 2.
- Fairness: both requesters always valid, stub always ready -> issue order of IDs is 0,1,0,1,0,1. The pointer wraps from 1 back to 0.
- Stall lock: req0 valid at cycle 0, cast_in_ready=0 for 3 cycles, req1 rises at cycle 1 -> grant stays 0 and cast_edata stays constant until acceptance. req1 is issued next.
- Tag full: TAG_DEPTH=4, stub never returns -> exactly 4 issues, then req_ready=0 and in_flight=4. Releasing one result on the same cycle req is valid -> simultaneous pop and push, in_flight stays 4.
- Return backpressure: results tagged 1,0 with rsp_ready[1]=0 for 5 cycles -> cast_out_ready=0 and rsp_valid=10 held. The result for req0 is delivered only after req1 accepts.
- Error and reset: cast_out_valid=1 with nothing issued -> tag_error=1 the next cycle, cast_out_ready=0. Asserting rst mid-traffic -> in_flight=0, tag_error=0, all ready/valid outputs 0 asynchronously.
